// File: rtl/rvfi_commit_tracker.sv
// Retire-stream monitor: order continuity, halt/post-halt, commit timeout and marker-delimited segment counters.
// All outputs registered one edge after the commit cycle; no flow control, a retire group is accepted every cycle.
module rvfi_commit_tracker #(
  parameter int NUM_CHANNELS   = 8,
  parameter int ORDER_WIDTH    = 64,
  parameter int CNT_WIDTH      = 64,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_CHANNELS-1:0]           valid,
  input  logic [NUM_CHANNELS*ORDER_WIDTH-1:0] order,
  input  logic [NUM_CHANNELS*32-1:0]        inst,
  input  logic [NUM_CHANNELS*32-1:0]        pc_rdata,
  input  logic [NUM_CHANNELS*32-1:0]        pc_wdata,
  output logic                              halt,
  output logic                              error,
  output logic [1:0]                        err_code,
  output logic [ORDER_WIDTH-1:0]            expected_order,
  output logic [1:0]                        seg_state,
  output logic [CNT_WIDTH-1:0]              seg_inst_count,
  output logic [CNT_WIDTH-1:0]              seg_cycle_count,
  output logic                              seg_done
);

  localparam logic [31:0] START_MARK = 32'h0010_2013;
  localparam logic [31:0] STOP_MARK  = 32'h0020_2013;
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {SEG_IDLE = 2'd0, SEG_RUN = 2'd1, SEG_DONE = 2'd2} seg_e;

  seg_e                   seg_q, seg_d;
  logic                   halt_q, halt_d;
  logic                   err_q, err_d;
  logic [1:0]             code_q, code_d;
  logic [ORDER_WIDTH-1:0] exp_q, exp_d, exp_run;
  logic [CNT_WIDTH-1:0]   icnt_q, icnt_d, ccnt_q, ccnt_d;
  logic                   done_q, done_d;
  logic [IDLE_W-1:0]      idle_q, idle_d;
  logic                   halt_seen, ord_err, ph_err, to_err;

  function automatic logic is_halt(input logic [31:0] ins, input logic [31:0] rd, input logic [31:0] wd);
    return (rd == wd) || (ins == 32'h0000_0063) || (ins == 32'h0000_006F) || (ins == 32'hF000_2013);
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Walk channels in index order: k-th valid channel must carry exp_q+k.
  always_comb begin
    exp_run   = exp_q;
    halt_seen = halt_q;
    ord_err   = 1'b0;
    ph_err    = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (valid[i]) begin
        if (order[i*ORDER_WIDTH +: ORDER_WIDTH] != exp_run) ord_err = 1'b1;
        if (halt_seen) ph_err = 1'b1;
        if (is_halt(inst[i*32 +: 32], pc_rdata[i*32 +: 32], pc_wdata[i*32 +: 32])) halt_seen = 1'b1;
        exp_run = exp_run + ORDER_WIDTH'(1);
      end
    end
    exp_d  = exp_run;
    halt_d = halt_seen;
  end

  always_comb begin
    idle_d = idle_q;
    if (|valid) idle_d = '0;
    else if (!halt_q && idle_q != IDLE_LIMIT) idle_d = idle_q + IDLE_W'(1);
    to_err = (TIMEOUT_CYCLES != 0) && !halt_q && !(|valid) && (idle_d == IDLE_LIMIT);
  end

  always_comb begin
    err_d  = err_q;
    code_d = code_q;
    if (!err_q) begin
      if (ord_err)     begin err_d = 1'b1; code_d = 2'd1; end
      else if (ph_err) begin err_d = 1'b1; code_d = 2'd2; end
      else if (to_err) begin err_d = 1'b1; code_d = 2'd3; end
    end
  end

  // Segment next-state: markers applied in channel order, last one wins.
  always_comb begin
    seg_d  = seg_q;
    icnt_d = icnt_q;
    ccnt_d = ccnt_q;
    done_d = 1'b0;
    if (seg_q != SEG_DONE) ccnt_d = sat_inc(ccnt_q);
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (valid[i]) begin
        if (inst[i*32 +: 32] == START_MARK) begin
          seg_d  = SEG_RUN;
          icnt_d = '0;
          ccnt_d = '0;
        end else if (inst[i*32 +: 32] == STOP_MARK && seg_d != SEG_DONE) begin
          icnt_d = sat_inc(icnt_d);
          seg_d  = SEG_DONE;
          done_d = 1'b1;
        end else if (seg_d != SEG_DONE) begin
          icnt_d = sat_inc(icnt_d);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) seg_q <= SEG_IDLE;
    else     seg_q <= seg_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      halt_q <= 1'b0;
      err_q  <= 1'b0;
      code_q <= 2'd0;
      exp_q  <= '0;
      icnt_q <= '0;
      ccnt_q <= '0;
      done_q <= 1'b0;
      idle_q <= '0;
    end else begin
      halt_q <= halt_d;
      err_q  <= err_d;
      code_q <= code_d;
      exp_q  <= exp_d;
      icnt_q <= icnt_d;
      ccnt_q <= ccnt_d;
      done_q <= done_d;
      idle_q <= idle_d;
    end
  end

  always_comb begin
    halt            = halt_q;
    error           = err_q;
    err_code        = code_q;
    expected_order  = exp_q;
    seg_state       = seg_q;
    seg_inst_count  = icnt_q;
    seg_cycle_count = ccnt_q;
    seg_done        = done_q;
  end

endmodule

// File: tb/tb_rvfi_commit_tracker.sv
// Bench for rvfi_commit_tracker: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_rvfi_commit_tracker;
  localparam int NC = 4;
  localparam int OW = 8;
  localparam int CW = 8;
  localparam int TO = 8;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] START = 32'h0010_2013;
  localparam logic [31:0] STOP  = 32'h0020_2013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NC-1:0]    valid;
  logic [NC*OW-1:0] order;
  logic [NC*32-1:0] inst, pc_rdata, pc_wdata;
  logic             halt, error, seg_done;
  logic [1:0]       err_code, seg_state;
  logic [OW-1:0]    expected_order;
  logic [CW-1:0]    seg_inst_count, seg_cycle_count;

  int checks = 0;
  int errors = 0;

  logic [NC-1:0] v;
  logic [OW-1:0] ord_a[NC];
  logic [31:0]   ins_a[NC], rd_a[NC], wd_a[NC];

  logic [OW-1:0] m_exp;
  bit            m_halt, m_err, m_done;
  int            m_code, m_idle, m_seg, m_icnt, m_ccnt;

  rvfi_commit_tracker #(.NUM_CHANNELS(NC), .ORDER_WIDTH(OW), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .valid(valid), .order(order), .inst(inst),
    .pc_rdata(pc_rdata), .pc_wdata(pc_wdata), .halt(halt), .error(error),
    .err_code(err_code), .expected_order(expected_order), .seg_state(seg_state),
    .seg_inst_count(seg_inst_count), .seg_cycle_count(seg_cycle_count), .seg_done(seg_done)
  );

  always #5 clk = ~clk;

  function automatic bit ch_halts(int c);
    return (rd_a[c] == wd_a[c]) || ins_a[c] == 32'h63 || ins_a[c] == 32'h6F || ins_a[c] == 32'hF000_2013;
  endfunction

  function automatic int sat(int x);
    return (x > 255) ? 255 : x;
  endfunction

  task automatic model_step();
    int vl[$];
    int first_h;
    bit oe, pe, te;
    if (rst) begin
      m_exp = '0; m_halt = 0; m_err = 0; m_code = 0; m_idle = 0;
      m_seg = 0; m_icnt = 0; m_ccnt = 0; m_done = 0;
      return;
    end
    for (int c = 0; c < NC; c++) if (v[c]) vl.push_back(c);
    oe = 0;
    first_h = -1;
    foreach (vl[k]) begin
      if (ord_a[vl[k]] != OW'(int'(m_exp) + k)) oe = 1;
      if (first_h < 0 && ch_halts(vl[k])) first_h = vl[k];
    end
    pe = (m_halt && vl.size() > 0) || (first_h >= 0 && vl[vl.size()-1] > first_h);
    if (vl.size() > 0) m_idle = 0;
    else if (!m_halt && m_idle < TO) m_idle++;
    te = !m_halt && vl.size() == 0 && m_idle == TO;
    if (!m_err) begin
      if (oe)      begin m_err = 1; m_code = 1; end
      else if (pe) begin m_err = 1; m_code = 2; end
      else if (te) begin m_err = 1; m_code = 3; end
    end
    if (first_h >= 0) m_halt = 1;
    m_exp = OW'(int'(m_exp) + vl.size());
    m_done = 0;
    if (m_seg != 2) m_ccnt = sat(m_ccnt + 1);
    foreach (vl[k]) begin
      if (ins_a[vl[k]] == START) begin
        m_seg = 1; m_icnt = 0; m_ccnt = 0;
      end else if (ins_a[vl[k]] == STOP && m_seg != 2) begin
        m_icnt = sat(m_icnt + 1); m_seg = 2; m_done = 1;
      end else if (m_seg != 2) begin
        m_icnt = sat(m_icnt + 1);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    valid = v;
    for (int c = 0; c < NC; c++) begin
      order[c*OW +: OW]    = ord_a[c];
      inst[c*32 +: 32]     = ins_a[c];
      pc_rdata[c*32 +: 32] = rd_a[c];
      pc_wdata[c*32 +: 32] = wd_a[c];
    end
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_stim();
    v = '0;
    for (int c = 0; c < NC; c++) begin
      ins_a[c] = NOP;
      rd_a[c]  = 32'h1000 + 32'(c * 16);
      wd_a[c]  = rd_a[c] + 32'd4;
      ord_a[c] = '0;
    end
  endtask

  task automatic fill_orders();
    int k;
    k = 0;
    for (int c = 0; c < NC; c++) if (v[c]) begin ord_a[c] = OW'(int'(m_exp) + k); k++; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_stim();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_stim();
    v = 4'b1111;
    ins_a[0] = START;
    step();
    step();
    rst = 1'b0;
    checks++; if ({halt, error, err_code, expected_order, seg_state, seg_inst_count, seg_cycle_count, seg_done} !== 31'd0) begin
      errors++; $display("FAIL reset_state: got h=%b e=%b c=%0d exp=%0d st=%0d ic=%0d cc=%0d d=%b want all zero",
        halt, error, err_code, expected_order, seg_state, seg_inst_count, seg_cycle_count, seg_done); end
  endtask

  task automatic test_order();
    do_reset();
    v = 4'b1011; ord_a[0] = 8'd0; ord_a[1] = 8'd1; ord_a[3] = 8'd2;
    step();
    checks++; if (expected_order !== 8'd3) begin errors++; $display("FAIL order_advance: got %0d want 3", expected_order); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL order_ok_noerr: got %b want 0", error); end
    clear_stim();
    v = 4'b0001; ord_a[0] = 8'd4;
    step();
    checks++; if ({error, err_code} !== 3'b1_01) begin errors++; $display("FAIL order_mismatch: got err=%b code=%0d want 1/1", error, err_code); end
    checks++; if (expected_order !== 8'd4) begin errors++; $display("FAIL order_adv_on_err: got %0d want 4", expected_order); end
  endtask

  task automatic test_segment();
    do_reset();
    v = 4'b1111; ins_a[1] = START; fill_orders();
    step();
    checks++; if ({seg_state, seg_inst_count, seg_cycle_count} !== {2'd1, 8'd2, 8'd0}) begin errors++;
      $display("FAIL seg_start: got st=%0d ic=%0d cc=%0d want 1/2/0", seg_state, seg_inst_count, seg_cycle_count); end
    for (int n = 0; n < 3; n++) begin clear_stim(); v = 4'b0011; fill_orders(); step(); end
    checks++; if ({seg_inst_count, seg_cycle_count} !== {8'd8, 8'd3}) begin errors++;
      $display("FAIL seg_run: got ic=%0d cc=%0d want 8/3", seg_inst_count, seg_cycle_count); end
    clear_stim(); v = 4'b0001; ins_a[0] = STOP; fill_orders();
    step();
    checks++; if ({seg_state, seg_inst_count, seg_cycle_count, seg_done} !== {2'd2, 8'd9, 8'd4, 1'b1}) begin errors++;
      $display("FAIL seg_stop: got st=%0d ic=%0d cc=%0d d=%b want 2/9/4/1", seg_state, seg_inst_count, seg_cycle_count, seg_done); end
    clear_stim(); v = 4'b0011; fill_orders();
    step();
    checks++; if ({seg_state, seg_inst_count, seg_cycle_count, seg_done} !== {2'd2, 8'd9, 8'd4, 1'b0}) begin errors++;
      $display("FAIL seg_frozen: got st=%0d ic=%0d cc=%0d d=%b want 2/9/4/0", seg_state, seg_inst_count, seg_cycle_count, seg_done); end
    clear_stim(); v = 4'b0101; ins_a[0] = START; fill_orders();
    step();
    checks++; if ({seg_state, seg_inst_count, seg_cycle_count} !== {2'd1, 8'd1, 8'd0}) begin errors++;
      $display("FAIL seg_restart: got st=%0d ic=%0d cc=%0d want 1/1/0", seg_state, seg_inst_count, seg_cycle_count); end
  endtask

  task automatic test_halt();
    do_reset();
    v = 4'b0110; ins_a[1] = 32'h0000_006F; fill_orders();
    step();
    checks++; if ({halt, error, err_code} !== 4'b1_1_10) begin errors++;
      $display("FAIL halt_posthalt: got h=%b e=%b c=%0d want 1/1/2", halt, error, err_code); end
    do_reset();
    v = 4'b1111; ins_a[3] = 32'hF000_2013; fill_orders();
    step();
    checks++; if ({halt, error} !== 2'b10) begin errors++; $display("FAIL halt_last_ch: got h=%b e=%b want 1/0", halt, error); end
    do_reset();
    v = 4'b0001; wd_a[0] = rd_a[0]; fill_orders();
    step();
    checks++; if ({halt, error} !== 2'b10) begin errors++; $display("FAIL halt_pc_eq: got h=%b e=%b want 1/0", halt, error); end
    clear_stim(); v = 4'b0100; fill_orders();
    step();
    checks++; if ({error, err_code} !== 3'b1_10) begin errors++; $display("FAIL commit_after_halt: got e=%b c=%0d want 1/2", error, err_code); end
  endtask

  task automatic test_timeout();
    do_reset();
    repeat (7) step();
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b want 0 after 7 idle", error); end
    step();
    checks++; if ({error, err_code} !== 3'b1_11) begin errors++; $display("FAIL timeout_fire: got e=%b c=%0d want 1/3", error, err_code); end
    do_reset();
    repeat (7) step();
    v = 4'b0001; fill_orders(); step(); clear_stim();
    repeat (7) step();
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL timeout_cleared: got %b want 0", error); end
    step();
    checks++; if ({error, err_code} !== 3'b1_11) begin errors++; $display("FAIL timeout_after_clear: got e=%b c=%0d want 1/3", error, err_code); end
    do_reset();
    v = 4'b0001; ins_a[0] = 32'h0000_0063; fill_orders(); step(); clear_stim();
    repeat (20) step();
    checks++; if ({halt, error} !== 2'b10) begin errors++; $display("FAIL timeout_halted: got h=%b e=%b want 1/0", halt, error); end
  endtask

  task automatic test_priority();
    do_reset();
    v = 4'b0001; ord_a[0] = 8'd5; step(); clear_stim();
    repeat (10) step();
    checks++; if ({error, err_code} !== 3'b1_01) begin errors++; $display("FAIL code_frozen: got e=%b c=%0d want 1/1", error, err_code); end
    do_reset();
    v = 4'b0011; ins_a[0] = 32'h0000_006F; ord_a[0] = 8'd9; ord_a[1] = 8'd1; step();
    checks++; if ({error, err_code} !== 3'b1_01) begin errors++; $display("FAIL prio_order_first: got e=%b c=%0d want 1/1", error, err_code); end
    do_reset();
    v = 4'b1111; ins_a[0] = START; fill_orders(); step();
    clear_stim(); v = 4'b0011; ins_a[0] = 32'h63; fill_orders(); step();
    rst = 1'b1; clear_stim(); v = 4'b1111; fill_orders(); step(); rst = 1'b0;
    checks++; if ({halt, error, err_code, expected_order, seg_state, seg_inst_count, seg_cycle_count, seg_done} !== 31'd0) begin
      errors++; $display("FAIL midrun_reset: got h=%b e=%b c=%0d exp=%0d st=%0d ic=%0d cc=%0d want all zero",
        halt, error, err_code, expected_order, seg_state, seg_inst_count, seg_cycle_count); end
  endtask

  task automatic test_markers_same_cycle();
    do_reset();
    v = 4'b1001; ins_a[0] = STOP; ins_a[3] = START; fill_orders(); step();
    checks++; if ({seg_state, seg_inst_count, seg_cycle_count} !== {2'd1, 8'd0, 8'd0}) begin errors++;
      $display("FAIL stop_then_start: got st=%0d ic=%0d cc=%0d want 1/0/0", seg_state, seg_inst_count, seg_cycle_count); end
    do_reset();
    v = 4'b1111; ins_a[0] = START; ins_a[3] = STOP; fill_orders(); step();
    checks++; if ({seg_state, seg_inst_count, seg_cycle_count, seg_done} !== {2'd2, 8'd3, 8'd0, 1'b1}) begin errors++;
      $display("FAIL start_then_stop: got st=%0d ic=%0d cc=%0d d=%b want 2/3/0/1", seg_state, seg_inst_count, seg_cycle_count, seg_done); end
    do_reset();
    step(); step();
    v = 4'b0011; ins_a[1] = STOP; fill_orders(); step();
    checks++; if ({seg_state, seg_inst_count, seg_cycle_count} !== {2'd2, 8'd2, 8'd3}) begin errors++;
      $display("FAIL stop_from_idle: got st=%0d ic=%0d cc=%0d want 2/2/3", seg_state, seg_inst_count, seg_cycle_count); end
  endtask

  task automatic test_wrap_saturate();
    do_reset();
    repeat (260) begin v = 4'b1111; fill_orders(); step(); end
    checks++; if (expected_order !== 8'd16) begin errors++; $display("FAIL order_wrap: got %0d want 16", expected_order); end
    checks++; if ({seg_inst_count, seg_cycle_count, error} !== {8'd255, 8'd255, 1'b0}) begin errors++;
      $display("FAIL cnt_saturate: got ic=%0d cc=%0d e=%b want 255/255/0", seg_inst_count, seg_cycle_count, error); end
  endtask

  task automatic test_random();
    logic [30:0] got, want;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      clear_stim();
      v = NC'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) v = '0;
      for (int c = 0; c < NC; c++) begin
        rd_a[c] = $urandom;
        wd_a[c] = ($urandom_range(0, 39) == 0) ? rd_a[c] : rd_a[c] + 32'd4;
        case ($urandom_range(0, 39))
          0, 1, 2: ins_a[c] = START;
          3, 4, 5: ins_a[c] = STOP;
          6:       ins_a[c] = 32'h6F;
          7:       ins_a[c] = 32'hF000_2013;
          8, 9:    ins_a[c] = $urandom;
          default: ins_a[c] = NOP;
        endcase
      end
      fill_orders();
      if ($urandom_range(0, 24) == 0) ord_a[$urandom_range(0, NC-1)] ^= 8'h01;
      step();
      got  = {halt, error, err_code, expected_order, seg_state, seg_inst_count, seg_cycle_count, seg_done};
      want = {m_halt, m_err, 2'(m_code), m_exp, 2'(m_seg), CW'(m_icnt), CW'(m_ccnt), m_done};
      checks++; if (got !== want) begin errors++; $display("FAIL random_cycle%0d: got %h want %h", n, got, want); end
    end
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded time limit, got no end want end");
    $fatal(1);
  end

  initial begin
    valid = '0; order = '0; inst = '0; pc_rdata = '0; pc_wdata = '0;
    clear_stim();
    test_reset();
    test_order();
    test_segment();
    test_halt();
    test_timeout();
    test_priority();
    test_markers_same_cycle();
    test_wrap_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
